// File: rtl/cdb_arbiter_if.sv
// Bundle of the FU completion ports, squash and the CDB broadcast.
// slave  : the arbiter side (takes completions, drives the CDB).
// master : the producer/consumer side (FUs, pipeline control, CDB listeners).
interface cdb_arbiter_if #(
   parameter int NUM_FU  = 4,
   parameter int XLEN    = 32,
   parameter int ROB_LEN = 32
);
   localparam int TAG_W = $clog2(ROB_LEN);
   localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [NUM_FU-1:0]       fu_valid;
   logic [NUM_FU*TAG_W-1:0] fu_tag;
   logic [NUM_FU*XLEN-1:0]  fu_value;
   logic [NUM_FU-1:0]       fu_ready;
   logic                    squash;
   logic                    cdb_valid;
   logic [TAG_W-1:0]        cdb_tag;
   logic [XLEN-1:0]         cdb_value;
   logic [IDX_W-1:0]        cdb_fu_idx;

   modport slave (
      input  fu_valid, fu_tag, fu_value, squash,
      output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_fu_idx
   );

   modport master (
      output fu_valid, fu_tag, fu_value, squash,
      input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_fu_idx
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding buffer per functional unit, a
// round-robin pick among the full buffers each cycle, and a registered
// broadcast of the winner. Tags and values are carried opaquely.
module cdb_arbiter #(
   parameter int NUM_FU  = 4,
   parameter int XLEN    = 32,
   parameter int ROB_LEN = 32
) (
   input  logic               clock,
   input  logic               reset,
   cdb_arbiter_if.slave       bus
);
   localparam int TAG_W = $clog2(ROB_LEN);
   localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [NUM_FU-1:0] hold_valid_r;
   logic [TAG_W-1:0]  hold_tag_r   [NUM_FU];
   logic [XLEN-1:0]   hold_value_r [NUM_FU];
   logic [IDX_W-1:0]  rr_ptr_r;

   logic [NUM_FU-1:0] grant_s;
   logic [IDX_W-1:0]  grant_idx_s;
   logic              grant_any_s;
   logic [NUM_FU-1:0] accept_s;

   // Round-robin pick: first full buffer at or after rr_ptr, wrapping.
   always_comb begin
      int cand;
      grant_s     = {NUM_FU{1'b0}};
      grant_idx_s = {IDX_W{1'b0}};
      grant_any_s = 1'b0;
      for (int off = 0; off < NUM_FU; off++) begin
         cand = int'(rr_ptr_r) + off;
         if (cand >= NUM_FU) begin
            cand = cand - NUM_FU;
         end else begin
            cand = cand;
         end
         if (!grant_any_s && hold_valid_r[cand]) begin
            grant_s[cand] = 1'b1;
            grant_idx_s   = IDX_W'(cand);
            grant_any_s   = 1'b1;
         end else begin
            grant_any_s   = grant_any_s;
         end
      end
   end

   // A buffer can take a new result when it is empty or is being drained
   // this cycle; depends on registered state and squash only.
   assign bus.fu_ready = ~{NUM_FU{bus.squash}} & (~hold_valid_r | grant_s);
   assign accept_s     = bus.fu_valid & bus.fu_ready;

   // Holding buffers, round-robin pointer and the registered CDB.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold_valid_r   <= {NUM_FU{1'b0}};
         rr_ptr_r       <= {IDX_W{1'b0}};
         bus.cdb_valid  <= 1'b0;
         bus.cdb_tag    <= {TAG_W{1'b0}};
         bus.cdb_value  <= {XLEN{1'b0}};
         bus.cdb_fu_idx <= {IDX_W{1'b0}};
         for (int i = 0; i < NUM_FU; i++) begin
            hold_tag_r[i]   <= {TAG_W{1'b0}};
            hold_value_r[i] <= {XLEN{1'b0}};
         end
      end else if (bus.squash) begin
         // Flush wins over both accept and broadcast; the last tag/value
         // stay on the bus but are qualified off by cdb_valid.
         hold_valid_r  <= {NUM_FU{1'b0}};
         rr_ptr_r      <= {IDX_W{1'b0}};
         bus.cdb_valid <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (accept_s[i]) begin
               // Refill replaces a granted entry in the same cycle.
               hold_valid_r[i] <= 1'b1;
               hold_tag_r[i]   <= bus.fu_tag[i*TAG_W +: TAG_W];
               hold_value_r[i] <= bus.fu_value[i*XLEN +: XLEN];
            end else if (grant_s[i]) begin
               hold_valid_r[i] <= 1'b0;
            end else begin
               hold_valid_r[i] <= hold_valid_r[i];
            end
         end
         if (grant_any_s) begin
            bus.cdb_valid  <= 1'b1;
            bus.cdb_tag    <= hold_tag_r[grant_idx_s];
            bus.cdb_value  <= hold_value_r[grant_idx_s];
            bus.cdb_fu_idx <= grant_idx_s;
            rr_ptr_r       <= (grant_idx_s == IDX_W'(NUM_FU - 1)) ?
                              {IDX_W{1'b0}} : grant_idx_s + IDX_W'(1);
         end else begin
            bus.cdb_valid  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by
// random traffic, all compared against a per-cycle reference model.
module tb_cdb_arbiter;
   localparam int NUM_FU  = 4;
   localparam int XLEN    = 32;
   localparam int ROB_LEN = 32;
   localparam int TAG_W   = 5;

   logic clock = 1'b0;
   logic reset = 1'b0;

   cdb_arbiter_if #(.NUM_FU(NUM_FU), .XLEN(XLEN), .ROB_LEN(ROB_LEN)) bus ();

   cdb_arbiter #(.NUM_FU(NUM_FU), .XLEN(XLEN), .ROB_LEN(ROB_LEN)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // Reference model: what each FU buffer holds, where the fair scan
   // starts, and what the bus currently shows.
   bit          m_full [NUM_FU];
   logic [4:0]  m_tag  [NUM_FU];
   logic [31:0] m_val  [NUM_FU];
   int          m_start;
   logic        m_cv;
   logic [4:0]  m_ct;
   logic [31:0] m_cval;
   logic [1:0]  m_cidx;
   logic [3:0]  exp_ready;

   function automatic void model_reset();
      for (int i = 0; i < NUM_FU; i++) begin
         m_full[i] = 1'b0;
         m_tag[i]  = 5'd0;
         m_val[i]  = 32'd0;
      end
      m_start = 0;
      m_cv    = 1'b0;
      m_ct    = 5'd0;
      m_cval  = 32'd0;
      m_cidx  = 2'd0;
   endfunction

   function automatic int model_winner();
      for (int off = 0; off < NUM_FU; off++) begin
         if (m_full[(m_start + off) % NUM_FU]) return (m_start + off) % NUM_FU;
      end
      return -1;
   endfunction

   function automatic logic [3:0] model_ready(input logic sq);
      logic [3:0] r;
      int w;
      w = model_winner();
      for (int i = 0; i < NUM_FU; i++) r[i] = !sq && (!m_full[i] || w == i);
      return r;
   endfunction

   function automatic void model_edge(input logic [3:0] v, input logic [19:0] tg,
                                      input logic [127:0] vl, input logic sq,
                                      input logic [3:0] rdy);
      int w;
      if (sq) begin
         for (int i = 0; i < NUM_FU; i++) m_full[i] = 1'b0;
         m_start = 0;
         m_cv    = 1'b0;
         return;
      end
      w = model_winner();
      if (w >= 0) begin
         m_cv    = 1'b1;
         m_ct    = m_tag[w];
         m_cval  = m_val[w];
         m_cidx  = 2'(w);
         m_start = (w + 1) % NUM_FU;
         m_full[w] = 1'b0;
      end else begin
         m_cv = 1'b0;
      end
      for (int i = 0; i < NUM_FU; i++) begin
         if (v[i] && rdy[i]) begin
            m_full[i] = 1'b1;
            m_tag[i]  = tg[i*5 +: 5];
            m_val[i]  = vl[i*32 +: 32];
         end
      end
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic chk_cdb(input string name);
      chk({name, ".valid"}, 64'(bus.cdb_valid), 64'(m_cv));
      chk({name, ".tag"},   64'(bus.cdb_tag),   64'(m_ct));
      chk({name, ".value"}, 64'(bus.cdb_value), 64'(m_cval));
      chk({name, ".idx"},   64'(bus.cdb_fu_idx), 64'(m_cidx));
   endtask

   // One clock: drive at the falling edge, check ready, advance the model
   // at the rising edge, check the bus at the next falling edge.
   task automatic step(input string name, input logic [3:0] v, input logic [19:0] tg,
                       input logic [127:0] vl, input logic sq);
      bus.fu_valid = v;
      bus.fu_tag   = tg;
      bus.fu_value = vl;
      bus.squash   = sq;
      #1;
      exp_ready = model_ready(sq);
      chk({name, ".ready"}, 64'(bus.fu_ready), 64'(exp_ready));
      @(posedge clock);
      model_edge(v, tg, vl, sq, exp_ready);
      @(negedge clock);
      chk_cdb(name);
   endtask

   function automatic logic [19:0] tags4(input int a, input int b, input int c, input int d);
      return {5'(d), 5'(c), 5'(b), 5'(a)};
   endfunction

   function automatic logic [127:0] vals4(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
      return {d, c, b, a};
   endfunction

   initial begin
      int seen;
      int fu1_at;
      logic [3:0] rv;
      logic [19:0] rt;
      logic [127:0] rvl;
      logic rs;

      // Reset held across three edges while every FU offers.
      model_reset();
      bus.fu_valid = 4'b1111;
      bus.fu_tag   = tags4(7, 8, 9, 10);
      bus.fu_value = vals4(32'h1, 32'h2, 32'h3, 32'h4);
      bus.squash   = 1'b0;
      for (int e = 0; e < 3; e++) begin
         @(posedge clock);
         @(negedge clock);
         chk("rst.valid", 64'(bus.cdb_valid), 64'd0);
         chk("rst.tag",   64'(bus.cdb_tag),   64'd0);
      end
      bus.fu_valid = 4'b0000;
      reset = 1'b1;
      #1;
      chk("rst.ready", 64'(bus.fu_ready), 64'hF);
      step("idle0", 4'b0000, 20'd0, 128'd0, 1'b0);
      step("idle1", 4'b0000, 20'd0, 128'd0, 1'b0);

      // Single result from FU2.
      step("single.offer", 4'b0100, tags4(0, 0, 5, 0), vals4(0, 0, 32'hDEAD_BEEF, 0), 1'b0);
      step("single.bcast", 4'b0000, 20'd0, 128'd0, 1'b0);
      chk("single.k.valid", 64'(bus.cdb_valid), 64'd1);
      chk("single.k.tag",   64'(bus.cdb_tag),   64'd5);
      chk("single.k.value", 64'(bus.cdb_value), 64'hDEAD_BEEF);
      chk("single.k.idx",   64'(bus.cdb_fu_idx), 64'd2);
      step("single.after", 4'b0000, 20'd0, 128'd0, 1'b0);
      chk("single.k.drop", 64'(bus.cdb_valid), 64'd0);

      // Squash to bring the scan start back to FU0, then four at once.
      step("sq0", 4'b0000, 20'd0, 128'd0, 1'b1);
      step("four.offer", 4'b1111, tags4(1, 2, 3, 4), vals4(32'h11, 32'h22, 32'h33, 32'h44), 1'b0);
      for (int k = 0; k < 4; k++) begin
         step("four.drain", 4'b0000, 20'd0, 128'd0, 1'b0);
         chk("four.k.tag", 64'(bus.cdb_tag), 64'(k + 1));
         chk("four.k.valid", 64'(bus.cdb_valid), 64'd1);
      end
      step("four.end", 4'b0000, 20'd0, 128'd0, 1'b0);

      // Fairness: FU0 streams, FU1 offers once.
      seen   = 0;
      fu1_at = -1;
      step("fair.offer", 4'b0011, tags4(20, 21, 0, 0), vals4(32'hA0, 32'hA1, 0, 0), 1'b0);
      for (int k = 0; k < 4; k++) begin
         step("fair.run", 4'b0001, tags4(22 + k, 0, 0, 0), vals4(32'hB0 + k, 0, 0, 0), 1'b0);
         if (bus.cdb_valid) begin
            seen++;
            if (bus.cdb_fu_idx == 2'd1 && fu1_at < 0) fu1_at = seen;
         end
      end
      chk("fair.bound", 64'(fu1_at >= 1 && fu1_at <= 2), 64'd1);
      step("fair.stop", 4'b0000, 20'd0, 128'd0, 1'b0);
      step("fair.stop2", 4'b0000, 20'd0, 128'd0, 1'b0);
      step("fair.stop3", 4'b0000, 20'd0, 128'd0, 1'b0);

      // Sustained throughput from FU3 alone.
      for (int k = 1; k <= 8; k++) begin
         step("stream", 4'b1000, tags4(0, 0, 0, k), vals4(0, 0, 0, 32'hC00 + k), 1'b0);
         chk("stream.ready3", 64'(exp_ready[3]), 64'd1);
      end
      for (int k = 0; k < 2; k++) step("stream.tail", 4'b0000, 20'd0, 128'd0, 1'b0);

      // Three pending then squash.
      step("sq.load", 4'b0111, tags4(9, 10, 11, 0), vals4(32'h9, 32'hA, 32'hB, 0), 1'b0);
      step("sq.hit", 4'b1111, tags4(1, 1, 1, 1), vals4(1, 1, 1, 1), 1'b1);
      chk("sq.k.valid", 64'(bus.cdb_valid), 64'd0);
      for (int k = 0; k < 3; k++) step("sq.after", 4'b0000, 20'd0, 128'd0, 1'b0);

      // Three pending then asynchronous reset between edges.
      step("ar.load", 4'b0111, tags4(12, 13, 14, 0), vals4(32'hC, 32'hD, 32'hE, 0), 1'b0);
      step("ar.bcast", 4'b0000, 20'd0, 128'd0, 1'b0);
      chk("ar.pre.valid", 64'(bus.cdb_valid), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      chk("ar.valid", 64'(bus.cdb_valid), 64'd0);
      chk("ar.tag",   64'(bus.cdb_tag),   64'd0);
      chk("ar.value", 64'(bus.cdb_value), 64'd0);
      chk("ar.ready", 64'(bus.fu_ready),  64'hF);
      @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 2; k++) step("ar.after", 4'b0000, 20'd0, 128'd0, 1'b0);

      // Random traffic with occasional squash.
      for (int n = 0; n < 400; n++) begin
         rv  = 4'($urandom);
         rt  = 20'($urandom);
         rvl = {$urandom, $urandom, $urandom, $urandom};
         rs  = ($urandom_range(0, 19) == 0);
         step("rand", rv, rt, rvl, rs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
